div_24x12_seq: RTL

DIV_24X12_SEQ -- requirements
Module: div_24x12_seq

---
 rtl/div_24x12_seq_if.sv | 23 ++
 rtl/div_24x12_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/div_24x12_seq_if.sv
// Handshake and result bundle for the 24/12 sequential divider.
// The master side issues operands with a start pulse; the slave side
// (the divider) reports busy/done and holds the results.
interface div_if;
  logic        start;
  logic [23:0] dividend;
  logic [11:0] divisor;
  logic        busy;
  logic        done;
  logic [23:0] quotient;
  logic [11:0] remainder;
  logic        dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/div_24x12_seq.sv
// Sequential restoring divider: 24-bit unsigned dividend by 12-bit unsigned
// divisor, one quotient bit per clock, MSB first. A zero divisor skips the
// iteration and reports all-ones quotient with the dbz flag set.
module div_24x12_seq (
  input  logic   clk,
  input  logic   rst,
  div_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  // Dividend shifts out at the MSB while quotient bits shift in at the LSB,
  // so after 24 steps this register holds the full quotient.
  logic [23:0] work_reg;
  logic [11:0] dvs_reg;
  logic [11:0] rem_reg;
  logic [23:0] quo_reg;
  logic [11:0] rem_out_reg;
  logic        dbz_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [12:0] partial;
  logic        fits;
  logic [11:0] rem_next;
  logic [23:0] work_next;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // The partial remainder is below 2*divisor, so the difference fits 12 bits.
  always_comb begin
    partial   = {rem_reg, work_reg[23]};
    fits      = (partial >= {1'b0, dvs_reg});
    rem_next  = fits ? 12'(partial - {1'b0, dvs_reg}) : partial[11:0];
    work_next = {work_reg[22:0], fits};
  end

  // Control FSM, datapath iteration and registered result/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 5'd0;
      work_reg    <= 24'd0;
      dvs_reg     <= 12'd0;
      rem_reg     <= 12'd0;
      quo_reg     <= 24'd0;
      rem_out_reg <= 12'd0;
      dbz_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          if (bus.start) begin
            work_reg <= bus.dividend;
            dvs_reg  <= bus.divisor;
            rem_reg  <= 12'd0;
            dbz_reg  <= 1'b0;
            if (bus.divisor != 12'd0) begin
              state_reg <= RUN;
              cnt_reg   <= 5'd23;
              busy_reg  <= 1'b1;
            end else begin
              // No iteration needed: results are defined directly.
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              quo_reg     <= 24'hFFFFFF;
              rem_out_reg <= bus.dividend[11:0];
              dbz_reg     <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          work_reg <= work_next;
          rem_reg  <= rem_next;
          if (cnt_reg == 5'd0) begin
            state_reg   <= DONE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            quo_reg     <= work_next;
            rem_out_reg <= rem_next;
          end else begin
            cnt_reg <= cnt_reg - 5'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = quo_reg;
  assign bus.remainder = rem_out_reg;
  assign bus.dbz       = dbz_reg;

endmodule
